// File: rtl/fetch_queue_if.sv
// Fetch-stage bus: redirect/interrupt controls, imem read port and decode handshake.
// The fetch stage connects through the master modport; its environment uses the slave modport.
interface fetch_queue_if #(
    parameter int XLEN     = 32,
    parameter int IQ_DEPTH = 4
);
    localparam int CW = $clog2(IQ_DEPTH + 1);

    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            irq;
    logic            rti;
    logic [XLEN-1:0] epc;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_rdata;

    logic            dec_valid;
    logic            dec_ready;
    logic [31:0]     dec_instr;
    logic [XLEN-1:0] dec_pc;
    logic [XLEN-1:0] dec_pc_next;
    logic [CW-1:0]   iq_count;

    modport master (
        input  redirect, redirect_pc, irq, rti, imem_rdata, dec_ready,
        output epc, imem_req, imem_addr, dec_valid, dec_instr, dec_pc, dec_pc_next, iq_count
    );

    modport slave (
        output redirect, redirect_pc, irq, rti, imem_rdata, dec_ready,
        input  epc, imem_req, imem_addr, dec_valid, dec_instr, dec_pc, dec_pc_next, iq_count
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch stage: credit-limited imem reads against a fixed-latency memory, a small
// instruction queue towards decode, and epoch-based discard of reads outstanding across a redirect.
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              IQ_DEPTH = 4,
    parameter int              MEM_LAT  = 1,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] IRQ_VEC  = XLEN'(4),
    parameter logic [31:0]     NOP      = 32'h13
) (
    input logic           clk,
    input logic           rst_n,
    fetch_queue_if.master bus
);
    localparam int AW = $clog2(IQ_DEPTH);
    localparam int CW = $clog2(IQ_DEPTH + 1);
    localparam int SW = $clog2(IQ_DEPTH + MEM_LAT + 1);

    typedef enum logic [1:0] {
        FL_NONE,
        FL_REDIRECT,
        FL_RTI,
        FL_IRQ
    } flush_e;

    // Fetch PC, saved return PC and current epoch
    logic [XLEN-1:0] r_fpc;
    logic [XLEN-1:0] r_epc;
    logic            r_epoch;

    // In-flight reads; index MEM_LAT-1 is the one whose data is on imem_rdata now
    logic [MEM_LAT-1:0] r_fl_valid;
    logic [MEM_LAT-1:0] r_fl_epoch;
    logic [XLEN-1:0]    r_fl_pc [MEM_LAT];

    // Instruction queue
    logic [31:0]     r_q_instr [IQ_DEPTH];
    logic [XLEN-1:0] r_q_pc    [IQ_DEPTH];
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;

    flush_e          w_flush_src;
    logic            w_flush;
    logic [SW-1:0]   w_used;
    logic            w_issue;
    logic            w_resp_hit;
    logic            w_push;
    logic            w_pop;
    logic            w_dec_valid;
    logic [31:0]     w_rdata_clean;
    logic [XLEN-1:0] w_head_pc;
    logic [XLEN-1:0] w_next_fpc;
    logic [XLEN-1:0] w_next_epc;

    // NOTE: combinational blocks use blocking '=' so later statements see earlier results;
    // every clocked block below uses non-blocking '<=' so all registers update together.
    always_comb begin
        // NOTE: assigning a default before any branch keeps this block free of inferred latches.
        w_flush_src = FL_NONE;
        if (bus.irq)           w_flush_src = FL_IRQ;
        else if (bus.rti)      w_flush_src = FL_RTI;
        else if (bus.redirect) w_flush_src = FL_REDIRECT;
    end

    assign w_flush = (w_flush_src != FL_NONE);

    // Credits: queued entries plus reads still in flight, stale ones included
    always_comb begin
        w_used = SW'(r_count);
        for (int i = 0; i < MEM_LAT; i++) begin
            w_used = w_used + SW'(r_fl_valid[i]);
        end
    end

    assign w_issue       = rst_n && !w_flush && (w_used < SW'(IQ_DEPTH));
    assign w_resp_hit    = r_fl_valid[MEM_LAT-1] && (r_fl_epoch[MEM_LAT-1] == r_epoch);
    assign w_push        = w_resp_hit && !w_flush;
    assign w_dec_valid   = (r_count != '0);
    assign w_pop         = w_dec_valid && bus.dec_ready && !w_flush;
    assign w_head_pc     = r_q_pc[r_rd_ptr];
    assign w_rdata_clean = ($isunknown(bus.imem_rdata) || (bus.imem_rdata == 32'h0))
                         ? NOP : bus.imem_rdata;

    always_comb begin
        w_next_fpc = r_fpc;
        w_next_epc = r_epc;
        case (w_flush_src)
            FL_IRQ: begin
                w_next_fpc = IRQ_VEC;
                if (bus.redirect)     w_next_epc = bus.redirect_pc;
                else if (w_dec_valid) w_next_epc = w_head_pc;
                else                  w_next_epc = r_fpc;
            end
            FL_RTI:      w_next_fpc = r_epc;
            FL_REDIRECT: w_next_fpc = bus.redirect_pc;
            default: begin
                if (w_issue) w_next_fpc = r_fpc + XLEN'(4);
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fpc   <= RESET_PC;
            r_epc   <= '0;
            r_epoch <= 1'b0;
        end else begin
            r_fpc <= w_next_fpc;
            r_epc <= w_next_epc;
            if (w_flush) r_epoch <= ~r_epoch;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fl_valid <= '0;
            r_fl_epoch <= '0;
            for (int i = 0; i < MEM_LAT; i++) r_fl_pc[i] <= '0;
        end else begin
            r_fl_valid[0] <= w_issue;
            r_fl_epoch[0] <= r_epoch;
            r_fl_pc[0]    <= r_fpc;
            for (int i = 1; i < MEM_LAT; i++) begin
                r_fl_valid[i] <= r_fl_valid[i-1];
                r_fl_epoch[i] <= r_fl_epoch[i-1];
                r_fl_pc[i]    <= r_fl_pc[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_push && w_pop) r_count <= r_count - CW'(1);
        end
    end

    // NOTE: queue storage has no reset; r_count gates every read, so stale contents are never seen.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_instr[r_wr_ptr] <= w_rdata_clean;
            r_q_pc[r_wr_ptr]    <= r_fl_pc[MEM_LAT-1];
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && !w_pop && (r_count == CW'(IQ_DEPTH))));

    assign bus.imem_req    = w_issue;
    assign bus.imem_addr   = r_fpc;
    assign bus.epc         = r_epc;
    assign bus.dec_valid   = w_dec_valid;
    assign bus.dec_instr   = w_dec_valid ? r_q_instr[r_rd_ptr] : NOP;
    assign bus.dec_pc      = w_dec_valid ? w_head_pc : '0;
    assign bus.dec_pc_next = w_dec_valid ? (w_head_pc + XLEN'(4)) : '0;
    assign bus.iq_count    = r_count;
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random redirect/irq/rti/stall traffic, compared
// every cycle against a queue-based reference model; one DUT with MEM_LAT=1 and one with MEM_LAT=3.
module tb_fetch_queue;
    localparam int          XLEN     = 32;
    localparam int          IQ_DEPTH = 4;
    localparam logic [31:0] NOP      = 32'h13;
    localparam logic [31:0] IRQ_VEC  = 32'h4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        irq = 1'b0;
    logic        rti = 1'b0;
    logic        dec_ready = 1'b0;
    bit          sel = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    fetch_queue_if #(.XLEN(XLEN), .IQ_DEPTH(IQ_DEPTH)) bus1 ();
    fetch_queue_if #(.XLEN(XLEN), .IQ_DEPTH(IQ_DEPTH)) bus3 ();

    fetch_queue #(.XLEN(XLEN), .IQ_DEPTH(IQ_DEPTH), .MEM_LAT(1), .RESET_PC(RESET_PC),
                  .IRQ_VEC(IRQ_VEC), .NOP(NOP))
        u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    fetch_queue #(.XLEN(XLEN), .IQ_DEPTH(IQ_DEPTH), .MEM_LAT(3), .RESET_PC(RESET_PC),
                  .IRQ_VEC(IRQ_VEC), .NOP(NOP))
        u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    assign bus1.redirect = redirect;  assign bus3.redirect = redirect;
    assign bus1.redirect_pc = redirect_pc;  assign bus3.redirect_pc = redirect_pc;
    assign bus1.irq = irq;  assign bus3.irq = irq;
    assign bus1.rti = rti;  assign bus3.rti = rti;
    assign bus1.dec_ready = dec_ready;  assign bus3.dec_ready = dec_ready;

    // Memory image: word i holds i+1, with one all-zero word and one unknown word
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h48) return 32'h0;
        if (a == 32'h4c) return 32'hxxxx_xxxx;
        return (a >> 2) + 32'd1;
    endfunction

    function automatic logic [31:0] exp_instr(input logic [31:0] a);
        logic [31:0] w;
        w = mem_word(a);
        return ($isunknown(w) || (w == 32'h0)) ? NOP : w;
    endfunction

    // Fixed-latency memories answering whatever each DUT requests
    logic        m1_v;
    logic [31:0] m1_a;
    logic [2:0]  m3_v;
    logic [31:0] m3_a [3];
    always @(posedge clk) begin
        m1_v    <= bus1.imem_req;
        m1_a    <= bus1.imem_addr;
        m3_v    <= {m3_v[1:0], bus3.imem_req};
        m3_a[0] <= bus3.imem_addr;
        m3_a[1] <= m3_a[0];
        m3_a[2] <= m3_a[1];
    end
    assign bus1.imem_rdata = m1_v ? mem_word(m1_a) : 32'hdead_beef;
    assign bus3.imem_rdata = m3_v[2] ? mem_word(m3_a[2]) : 32'hdead_beef;

    logic        s_dv, s_req;
    logic [31:0] s_instr, s_pc, s_pcn, s_addr, s_epc;
    logic [2:0]  s_cnt;
    assign s_dv    = sel ? bus3.dec_valid   : bus1.dec_valid;
    assign s_req   = sel ? bus3.imem_req    : bus1.imem_req;
    assign s_instr = sel ? bus3.dec_instr   : bus1.dec_instr;
    assign s_pc    = sel ? bus3.dec_pc      : bus1.dec_pc;
    assign s_pcn   = sel ? bus3.dec_pc_next : bus1.dec_pc_next;
    assign s_addr  = sel ? bus3.imem_addr   : bus1.imem_addr;
    assign s_epc   = sel ? bus3.epc         : bus1.epc;
    assign s_cnt   = sel ? bus3.iq_count    : bus1.iq_count;

    // Reference model: queue of delivered words, list of outstanding reads with due cycle
    typedef struct packed { logic [31:0] instr; logic [31:0] pc; } ent_t;
    typedef struct packed { int due; bit ep; logic [31:0] pc; } fl_t;
    ent_t        mq[$];
    fl_t         mf[$];
    int          cyc, lat;
    bit          m_ep;
    logic [31:0] m_fpc, m_epc;

    task automatic model_reset();
        mq.delete();
        mf.delete();
        cyc   = 0;
        lat   = sel ? 3 : 1;
        m_ep  = 1'b0;
        m_fpc = RESET_PC;
        m_epc = '0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs, compare against the model, advance the model past the edge
    task automatic tick(input bit rd, input logic [31:0] rpc, input bit iq, input bit rt, input bit rdy);
        bit          hv, flush, req;
        logic [31:0] hpc, old_epc;
        fl_t         r;
        ent_t        e;
        redirect = rd; redirect_pc = rpc; irq = iq; rti = rt; dec_ready = rdy;
        #1;
        hv    = (mq.size() > 0);
        hpc   = hv ? mq[0].pc : 32'h0;
        flush = iq || rt || rd;
        req   = !flush && ((mq.size() + mf.size()) < IQ_DEPTH);
        check("dec_valid", 32'(s_dv), 32'(hv));
        check("dec_pc", s_pc, hpc);
        check("dec_pc_next", s_pcn, hv ? hpc + 32'd4 : 32'h0);
        check("dec_instr", s_instr, hv ? mq[0].instr : NOP);
        check("iq_count", 32'(s_cnt), 32'(mq.size()));
        check("imem_req", 32'(s_req), 32'(req));
        check("epc", s_epc, m_epc);
        if (req) check("imem_addr", s_addr, m_fpc);
        if (hv && rdy && !flush) void'(mq.pop_front());
        if (mf.size() > 0 && mf[0].due == cyc) begin
            r = mf.pop_front();
            if (!flush && r.ep == m_ep) begin
                e.instr = exp_instr(r.pc);
                e.pc    = r.pc;
                mq.push_back(e);
            end
        end
        if (flush) mq.delete();
        if (req) begin
            r.due = cyc + lat; r.ep = m_ep; r.pc = m_fpc;
            mf.push_back(r);
            m_fpc = m_fpc + 32'd4;
        end
        if (flush) begin
            old_epc = m_epc;
            if (iq) begin
                m_epc = rd ? rpc : (hv ? hpc : m_fpc);
                m_fpc = IRQ_VEC;
            end else if (rt) m_fpc = old_epc;
            else             m_fpc = rpc;
            m_ep = ~m_ep;
        end
        cyc++;
        @(negedge clk);
        redirect = 1'b0; irq = 1'b0; rti = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; redirect = 1'b0; irq = 1'b0; rti = 1'b0; dec_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_dec_valid", 32'(s_dv), 32'h0);
        check("rst_iq_count", 32'(s_cnt), 32'h0);
        check("rst_imem_req", 32'(s_req), 32'h0);
        check("rst_epc", s_epc, 32'h0);
        check("rst_dec_instr", s_instr, NOP);
        check("rst_dec_pc", s_pc, 32'h0);
        check("rst_dec_pc_next", s_pcn, 32'h0);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic wait_valid(input int budget, input bit rdy);
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            if (s_dv) ok = 1'b1;
            else      tick(1'b0, 32'h0, 1'b0, 1'b0, rdy);
        end
        check("wait_dec_valid", 32'(ok), 32'h1);
    endtask

    task automatic rand_run(input int n);
        int          r;
        bit          rd, iq, rt, rdy;
        logic [31:0] rpc;
        for (int i = 0; i < n; i++) begin
            r   = int'($urandom_range(0, 63));
            rd  = (r < 4) || (r == 8);
            iq  = (r == 4) || (r == 5);
            rt  = (r == 6) || (r == 7);
            rpc = (r == 8) ? 32'hffff_fff8 : ($urandom() & 32'h0000_03fc);
            rdy = ($urandom_range(0, 3) != 0);
            tick(rd, rpc, iq, rt, rdy);
        end
    endtask

    initial begin
        bit f48, f4c;

        // T1: sequential fetch, first delivery two cycles after reset
        sel = 1'b0;
        do_reset();
        tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        check("t1_c1_valid", 32'(s_dv), 32'h0);
        tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("t1_valid", 32'(s_dv), 32'h1);
            check("t1_pc", s_pc, 32'(4 * i));
            check("t1_instr", s_instr, 32'(i + 1));
            tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        end

        // T2: stall fills the queue, then drains in order
        do_reset();
        repeat (10) tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("t2_count_full", 32'(s_cnt), 32'd4);
        check("t2_req_low", 32'(s_req), 32'h0);
        for (int i = 0; i < 4; i++) begin
            check("t2_valid", 32'(s_dv), 32'h1);
            check("t2_pc", s_pc, 32'(4 * i));
            tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        end

        // T3: redirect with two queued entries and one read in flight
        do_reset();
        repeat (3) tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("t3_count_pre", 32'(s_cnt), 32'd2);
        tick(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
        check("t3_count_flush", 32'(s_cnt), 32'd0);
        wait_valid(8, 1'b1);
        check("t3_pc", s_pc, 32'h100);

        // T4: irq under stall saves head PC, rti returns there
        tick(1'b1, 32'h20, 1'b0, 1'b0, 1'b0);
        wait_valid(8, 1'b0);
        check("t4_head", s_pc, 32'h20);
        tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        check("t4_epc", s_epc, 32'h20);
        wait_valid(8, 1'b1);
        check("t4_irq_pc", s_pc, IRQ_VEC);
        repeat (3) tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        wait_valid(8, 1'b1);
        check("t4_rti_pc", s_pc, 32'h20);

        // T5: irq beats redirect and rti in the same cycle
        tick(1'b1, 32'h200, 1'b1, 1'b0, 1'b1);
        check("t5_epc", s_epc, 32'h200);
        wait_valid(8, 1'b1);
        check("t5_irq_pc", s_pc, IRQ_VEC);
        tick(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        wait_valid(8, 1'b1);
        check("t5_irq_rti_pc", s_pc, IRQ_VEC);

        rand_run(400);

        // T6: three-cycle memory, zero/unknown words, reset in mid-stream
        sel = 1'b1;
        do_reset();
        rand_run(300);
        tick(1'b1, 32'h40, 1'b0, 1'b0, 1'b1);
        f48 = 1'b0; f4c = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (s_dv && s_pc == 32'h48) begin
                f48 = 1'b1;
                check("t6_zero_nop", s_instr, NOP);
            end
            if (s_dv && s_pc == 32'h4c) begin
                f4c = 1'b1;
                check("t6_x_word", s_instr, exp_instr(32'h4c));
            end
            tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        end
        check("t6_seen_48", 32'(f48), 32'h1);
        check("t6_seen_4c", 32'(f4c), 32'h1);
        repeat (6) tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("t6_pre_rst_valid", 32'(s_dv), 32'h1);
        #3 rst_n = 1'b0;
        #1;
        check("t6_async_valid", 32'(s_dv), 32'h0);
        check("t6_async_count", 32'(s_cnt), 32'h0);
        check("t6_async_req", 32'(s_req), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        wait_valid(10, 1'b1);
        check("t6_restart_pc", s_pc, RESET_PC);
        check("t6_restart_instr", s_instr, 32'h1);
        rand_run(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end
endmodule
